dac_spi_receiver: RTL and testbench
===================================

# dac_spi_receiver

SPI responder for 32-bit DAC command frames in the LTC2624 word format used on the Spartan-3E board. It oversamples the chip-select, serial-clock and MOSI lines in the `clock_in` domain and assembles MSB-first frames. It decodes each frame's command, address and 12-bit data, and keeps four channel input/DAC registers. It also echoes the previous frame on MISO. It is the slave end for the team's DAC frame transmitter, used on-chip as a loopback checker and as a DAC stand-in.

## Interface
Parameters:
- `FRAME_BITS`, 32: required bit count per frame.
- `SYNC_STAGES`, 2: synchronizer depth on `select`, `spi_clock` and `MOSI`.

Ports:
- `clock_in`, input, 1: system clock; all logic is on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `select`, input, 1: SPI chip select, active low.
- `spi_clock`, input, 1: SPI serial clock.
- `MOSI`, input, 1: serial data in, MSB first.
- `MISO`, output, 1: echo of the previous valid 32-bit frame, MSB first.
- `frame_valid`, output, 1: one-cycle pulse when a correct-length frame completes.
- `frame_error`, output, 1: one-cycle pulse when a frame completes with the wrong length.
- `command`, output, 4: command field of the last valid frame.
- `address`, output, 4: address field of the last valid frame.
- `data`, output, 12: data field of the last valid frame.
- `dac_value`, output, 48: DAC registers; channel n occupies [12n+11:12n].
- `powered_down`, output, 4: per-channel power-down flags.

## Operation
Frame layout, bit 31 first:
- [31:24] don't-care.
- [23:20] command.
- [19:16] address.
- [15:4] data.
- [3:0] don't-care.

Input conditioning:
- `select`, `spi_clock` and `MOSI` each pass through a `SYNC_STAGES`-flop synchronizer.
- Edges are detected on the synchronized `select` and `spi_clock`.
- `MOSI` is sampled on the detected `spi_clock` rising edge.

State machine:
- IDLE: waits for a `select` falling edge. On that edge it clears the bit counter and shift register and goes to SHIFT. `spi_clock` activity in IDLE is ignored.
- SHIFT: each `spi_clock` rise shifts `MOSI` into the shift register LSB and increments the 6-bit bit counter. The counter saturates at 33. A `select` rise moves to DONE.
- DONE: lasts one cycle, then returns to IDLE.
  - Bit count equal to 32: pulse `frame_valid`, load `command`/`address`/`data`, execute the command, and load the echo register with the frame.
  - Any other count: pulse `frame_error` and change nothing else.
- A `select` falling edge seen in DONE is honoured: the block goes to SHIFT on the next cycle.

Commands (address 0–3 selects a channel; 1111 selects all channels; addresses 4–14 are no-op except for field capture):
- 0000: write input register.
- 0001: update DAC register from the input register.
- 0010: write input register, then update all DAC registers.
- 0011: write input register and update its DAC register.
- 0100: power down; sets `powered_down` for the channel.
- 1111: no-op.
- Other codes: no-op.
- Any DAC-register update to a channel clears that channel's `powered_down`.

MISO:
- On a `select` falling edge, MISO drives echo[31].
- After each sampled `spi_clock` rise, MISO advances to the next lower bit on the following detected `spi_clock` fall.
- While `select` is high, MISO is 0.

## Timing
- Reset values: all outputs 0, all input and DAC registers 0, state IDLE, echo register 0.
- If `select` is low when reset releases, the block stays in IDLE until a genuine falling edge.
- `spi_clock` high time and low time must each be at least 3 `clock_in` cycles. The transmitter's `clock_in`/8 clock meets this.
- Sampling latency: a bit is captured `SYNC_STAGES`+1 cycles after the `spi_clock` rise.
- Frame latency: `frame_valid` or `frame_error` rises exactly `SYNC_STAGES`+2 cycles after `select` rises (4 with defaults).
- `command`, `address`, `data`, `dac_value` and `powered_down` change in the same cycle as the `frame_valid` pulse and hold until the next valid frame.
- MISO changes `SYNC_STAGES`+1 cycles after the `spi_clock` fall.
- A `reset_n` assertion mid-frame aborts the frame immediately; the partial frame is discarded.

## Test plan
- Frame 0x0030ABC0 -> `frame_valid` pulse 4 cycles after `select` rises; `command`=3, `address`=0, `data`=0xABC; `dac_value`[11:0]=0xABC; other channels stay 0.
- Frame 0x00021230 (write input, ch2) -> `dac_value`[35:24] stays 0. Then frame 0x00120000 -> `dac_value`[35:24]=0x123.
- Frame 0x003FFFF0 (broadcast) -> all four channels 0xFFF. Then frame 0x00410000 -> `powered_down`=0010. Then frame 0x00315550 -> `powered_down`=0000 and ch1=0x555.
- 31-bit frame, then 33-bit frame -> two `frame_error` pulses, no `frame_valid`, all registers unchanged.
- Frame 0xDEADBEEF, then frame 0x12345678 -> MISO bit sequence during the second frame is 0xDEADBEEF.
- `reset_n` pulsed low after 16 bits of a frame -> all outputs 0 at once, no valid/error pulse. Next full frame 0x0030ABC0 decodes correctly.

Source files
------------

// File: rtl/dac_spi_receiver.sv
// SPI responder for 32-bit LTC2624-format DAC command frames, oversampled in the clock_in domain.
// Decodes command/address/data, keeps four input/DAC channel registers, and echoes the last frame on MISO.
module dac_spi_receiver #(
  parameter int FRAME_BITS  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic        select,
  input  logic        spi_clock,
  input  logic        MOSI,
  output logic        MISO,
  output logic        frame_valid,
  output logic        frame_error,
  output logic [3:0]  command,
  output logic [3:0]  address,
  output logic [11:0] data,
  output logic [47:0] dac_value,
  output logic [3:0]  powered_down
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [5:0] CNT_FULL = 6'(FRAME_BITS);
  localparam logic [5:0] CNT_SAT  = 6'(FRAME_BITS + 1);

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sel_sync, sck_sync, mosi_sync;
  logic                   sel_prev, sck_prev;
  logic                   sel_s, sck_s, mosi_s;
  logic                   sel_fall, sel_rise, sck_rise, sck_fall;

  logic [5:0]  cnt;
  logic [31:0] shreg;
  logic [31:0] echo;
  logic        frame_ok;

  logic [11:0] in_reg   [4];
  logic [11:0] dac_reg  [4];
  logic [11:0] in_next  [4];
  logic [11:0] dac_next [4];
  logic [3:0]  pd_next;
  logic [3:0]  hit;
  logic [3:0]  f_cmd, f_addr;
  logic [11:0] f_data;
  logic        addr_ok;

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == CNT_SAT) ? v : v + 6'd1;
  endfunction

  // Synchronizers reset low so a select already low at reset release is not seen as a falling edge.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sel_sync  <= '0;
      sck_sync  <= '0;
      mosi_sync <= '0;
      sel_prev  <= 1'b0;
      sck_prev  <= 1'b0;
    end else begin
      sel_sync  <= {sel_sync[SYNC_STAGES-2:0], select};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clock};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sel_prev  <= sel_s;
      sck_prev  <= sck_s;
    end
  end

  assign sel_s    = sel_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sel_fall = sel_prev & ~sel_s;
  assign sel_rise = ~sel_prev & sel_s;
  assign sck_rise = ~sck_prev & sck_s;
  assign sck_fall = sck_prev & ~sck_s;

  assign frame_ok = (cnt == CNT_FULL);
  assign f_cmd    = shreg[23:20];
  assign f_addr   = shreg[19:16];
  assign f_data   = shreg[15:4];
  assign addr_ok  = (f_addr < 4'd4) || (f_addr == 4'hF);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sel_fall) state_next = SHIFT;
      SHIFT:   if (sel_rise) state_next = DONE;
      DONE:    state_next = sel_fall ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command execution on the captured frame; address 15 broadcasts, 4..14 leave channels untouched.
  always_comb begin
    hit      = '0;
    pd_next  = powered_down;
    for (int n = 0; n < 4; n++) begin
      in_next[n]  = in_reg[n];
      dac_next[n] = dac_reg[n];
      hit[n]      = (f_addr == 4'(n)) || (f_addr == 4'hF);
      case (f_cmd)
        4'h0: if (hit[n]) in_next[n] = f_data;
        4'h1: if (hit[n]) begin
          dac_next[n] = in_reg[n];
          pd_next[n]  = 1'b0;
        end
        4'h2: if (addr_ok) begin
          in_next[n]  = hit[n] ? f_data : in_reg[n];
          dac_next[n] = hit[n] ? f_data : in_reg[n];
          pd_next[n]  = 1'b0;
        end
        4'h3: if (hit[n]) begin
          in_next[n]  = f_data;
          dac_next[n] = f_data;
          pd_next[n]  = 1'b0;
        end
        4'h4: if (hit[n]) pd_next[n] = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= '0;
      shreg        <= '0;
      echo         <= '0;
      MISO         <= 1'b0;
      frame_valid  <= 1'b0;
      frame_error  <= 1'b0;
      command      <= '0;
      address      <= '0;
      data         <= '0;
      powered_down <= '0;
      for (int n = 0; n < 4; n++) begin
        in_reg[n]  <= '0;
        dac_reg[n] <= '0;
      end
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: if (sel_fall) begin
          cnt   <= '0;
          shreg <= '0;
          MISO  <= echo[31];
        end
        SHIFT: begin
          if (sck_rise) begin
            shreg <= {shreg[30:0], mosi_s};
            cnt   <= sat_inc(cnt);
          end
          // MISO steps to the bit after the ones already clocked in by the master.
          if (sck_fall) MISO <= (cnt < 6'd32) ? echo[5'd31 - cnt[4:0]] : 1'b0;
          if (sel_rise) MISO <= 1'b0;
        end
        DONE: begin
          if (frame_ok) begin
            frame_valid  <= 1'b1;
            command      <= f_cmd;
            address      <= f_addr;
            data         <= f_data;
            echo         <= shreg;
            powered_down <= pd_next;
            for (int n = 0; n < 4; n++) begin
              in_reg[n]  <= in_next[n];
              dac_reg[n] <= dac_next[n];
            end
          end else begin
            frame_error <= 1'b1;
          end
          if (sel_fall) begin
            cnt   <= '0;
            shreg <= '0;
            MISO  <= frame_ok ? shreg[31] : echo[31];
          end
        end
        default: ;
      endcase
    end
  end

  assign dac_value = {dac_reg[3], dac_reg[2], dac_reg[1], dac_reg[0]};

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Directed bench for dac_spi_receiver: drives SPI frames at clock_in/8 and scores decode,
// channel registers, frame pulses and MISO echo against a reference model.
module tb_dac_spi_receiver;

  logic        clock_in = 1'b0;
  logic        reset_n;
  logic        select;
  logic        spi_clock;
  logic        MOSI;
  logic        MISO;
  logic        frame_valid;
  logic        frame_error;
  logic [3:0]  command;
  logic [3:0]  address;
  logic [11:0] data;
  logic [47:0] dac_value;
  logic [3:0]  powered_down;

  always #5 clock_in = ~clock_in;

  dac_spi_receiver #(.FRAME_BITS(32), .SYNC_STAGES(2)) dut (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .select       (select),
    .spi_clock    (spi_clock),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .frame_valid  (frame_valid),
    .frame_error  (frame_error),
    .command      (command),
    .address      (address),
    .data         (data),
    .dac_value    (dac_value),
    .powered_down (powered_down)
  );

  typedef struct {
    bit          valid;
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [11:0] data;
    logic [47:0] dac;
    logic [3:0]  pd;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  bit stray  = 1'b0;

  logic [11:0] m_in  [4];
  logic [11:0] m_dac [4];
  logic [3:0]  m_pd, m_cmd, m_addr;
  logic [11:0] m_data;
  logic [31:0] m_echo;
  logic [31:0] miso_seen;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock_in);
      stray = stray | frame_valid | frame_error;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_in[i]  = '0;
      m_dac[i] = '0;
    end
    m_pd = '0; m_cmd = '0; m_addr = '0; m_data = '0; m_echo = '0;
  endtask

  function automatic logic [47:0] m_dac_flat();
    return {m_dac[3], m_dac[2], m_dac[1], m_dac[0]};
  endfunction

  task automatic model_frame(input logic [31:0] w, input int n);
    exp_t e;
    logic [3:0]  c, a;
    logic [11:0] d;
    bit          sel_ch;
    if (n == 32) begin
      c = w[23:20]; a = w[19:16]; d = w[15:4];
      for (int ch = 0; ch < 4; ch++) begin
        sel_ch = (a == 4'(ch)) || (a == 4'hF);
        if (sel_ch && (c == 4'h0 || c == 4'h2 || c == 4'h3)) m_in[ch] = d;
        if (sel_ch && c == 4'h1) begin m_dac[ch] = m_in[ch]; m_pd[ch] = 1'b0; end
        if (sel_ch && c == 4'h3) begin m_dac[ch] = d; m_pd[ch] = 1'b0; end
        if (sel_ch && c == 4'h4) m_pd[ch] = 1'b1;
      end
      if (c == 4'h2 && (a < 4'd4 || a == 4'hF))
        for (int ch = 0; ch < 4; ch++) begin m_dac[ch] = m_in[ch]; m_pd[ch] = 1'b0; end
      m_cmd = c; m_addr = a; m_data = d; m_echo = w;
    end
    e.valid = (n == 32);
    e.cmd = m_cmd; e.addr = m_addr; e.data = m_data; e.dac = m_dac_flat(); e.pd = m_pd;
    sb.push_back(e);
  endtask

  // Sends the low n bits of w MSB first, then scores the frame result against the scoreboard head.
  task automatic send_frame(input string tag, input logic [32:0] w, input int n);
    exp_t        e;
    logic [31:0] prev_echo;
    prev_echo = m_echo;
    model_frame(w[31:0], n);
    miso_seen = '0;
    stray = 1'b0;
    select = 1'b0;
    tick(4);
    for (int i = n - 1; i >= 0; i--) begin
      MOSI = w[i];
      tick(4);
      miso_seen = {miso_seen[30:0], MISO};
      spi_clock = 1'b1;
      tick(4);
      spi_clock = 1'b0;
    end
    tick(4);
    select = 1'b1;
    MOSI = 1'b0;
    tick(3);
    check({tag, "_no_early_pulse"}, 48'(stray), 48'd0);
    tick(1);
    e = sb.pop_front();
    check({tag, "_valid"}, 48'(frame_valid), 48'(e.valid));
    check({tag, "_error"}, 48'(frame_error), 48'(!e.valid));
    check({tag, "_command"}, 48'(command), 48'(e.cmd));
    check({tag, "_address"}, 48'(address), 48'(e.addr));
    check({tag, "_data"}, 48'(data), 48'(e.data));
    check({tag, "_dac"}, dac_value, e.dac);
    check({tag, "_pd"}, 48'(powered_down), 48'(e.pd));
    if (n == 32) check({tag, "_miso_echo"}, 48'(miso_seen), 48'(prev_echo));
    tick(1);
    check({tag, "_pulse_end"}, 48'({frame_valid, frame_error}), 48'd0);
  endtask

  initial begin
    model_reset();
    select = 1'b0; spi_clock = 1'b0; MOSI = 1'b0; reset_n = 1'b0;
    tick(3);
    check("reset_dac", dac_value, 48'd0);
    check("reset_fields", 48'({command, address, data, powered_down}), 48'd0);
    check("reset_pulses_miso", 48'({frame_valid, frame_error, MISO}), 48'd0);
    reset_n = 1'b1;
    tick(6);
    stray = 1'b0;
    select = 1'b1;
    tick(10);
    check("select_low_at_release", 48'(stray), 48'd0);

    send_frame("wr_upd_ch0", 33'h0_0030ABC0, 32);
    check("ch0_value", 48'(dac_value[11:0]), 48'hABC);
    send_frame("wr_in_ch2", 33'h0_00021230, 32);
    check("ch2_unchanged", 48'(dac_value[35:24]), 48'h000);
    send_frame("upd_ch2", 33'h0_00120000, 32);
    check("ch2_value", 48'(dac_value[35:24]), 48'h123);
    send_frame("broadcast", 33'h0_003FFFF0, 32);
    check("all_fff", dac_value, 48'hFFF_FFF_FFF_FFF);
    send_frame("pwrdn_ch1", 33'h0_00410000, 32);
    check("pd_ch1", 48'(powered_down), 48'h2);
    send_frame("wake_ch1", 33'h0_00315550, 32);
    check("ch1_555", 48'(dac_value[23:12]), 48'h555);
    send_frame("short31", 33'h0_12345678, 31);
    send_frame("long33", 33'h1_2345678A, 33);
    send_frame("echo_src", 33'h0_DEADBEEF, 32);
    send_frame("echo_chk", 33'h0_12345678, 32);
    check("miso_deadbeef", 48'(miso_seen), 48'hDEADBEEF);

    // Abort a frame halfway with reset.
    stray = 1'b0;
    select = 1'b0;
    tick(4);
    for (int i = 31; i >= 16; i--) begin
      MOSI = i[0];
      tick(4);
      spi_clock = 1'b1;
      tick(4);
      spi_clock = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    model_reset();
    check("abort_dac", dac_value, 48'd0);
    check("abort_fields", 48'({command, address, data, powered_down}), 48'd0);
    check("abort_pulses_miso", 48'({frame_valid, frame_error, MISO}), 48'd0);
    tick(2);
    select = 1'b1;
    MOSI = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(10);
    check("abort_no_pulse", 48'(stray), 48'd0);
    send_frame("after_abort", 33'h0_0030ABC0, 32);
    check("after_abort_ch0", dac_value, 48'h000_000_000_ABC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
